cpu_ctrl: RTL
=============

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL have parameter FETCH_TIMEOUT, default 15, meaning the maximum number of wait cycles for mem_rdy in FETCH or MEM before the error state (range 1..255).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ins_in  input  16  current instruction from the instruction register output.
REQ-005 mem_rdy  input  1  memory transfer complete this cycle.
REQ-006 z_in  input  1  zero flag; n_in  input  1  negative flag.
REQ-007 il_out  output  1  instruction-register load enable.
REQ-008 pc_inc  output  1  PC += 1; pc_load  output  1  PC <= PC + ia (branch/jump).
REQ-009 mem_rd  output  1  memory read strobe; mem_we  output  1  memory write strobe.
REQ-010 addr_sel  output  1  0 = memory address from PC, 1 = memory address from register file.
REQ-011 rf_we  output  1  register-file write; wb_sel  output  2  write source: 0 = ALU, 1 = iv immediate, 2 = memory.
REQ-012 alu_op  output  3  ALU function.
REQ-013 state_out  output  3  current state code.
REQ-014 halted_out  output  1  core halted; err_out  output  1  error latched.
REQ-015 instr_cnt  output  16  count of decoded instructions.

Function
REQ-016 The opcode SHALL be ins_in[15:12], decoded as follows:
- 0x0 NOP
- 0x1-0x7 ALU, with alu_op = opcode[2:0]
- 0x8 LDI
- 0x9 LD
- 0xA ST
- 0xB BZ
- 0xC BN
- 0xD JMP
- 0xE illegal
- 0xF HALT
REQ-017 The states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6, and state_out SHALL equal the state code.
REQ-018 Outputs SHALL be combinational from the state register, opcode, flags and mem_rdy; any output not listed for a state SHALL be 0.
REQ-019 FETCH SHALL behave as follows:
- mem_rd=1, addr_sel=0.
- On mem_rdy=1: il_out=1 and pc_inc=1 in that same cycle, and the next state is DECODE.
- Otherwise the block stays in FETCH.
REQ-020 DECODE SHALL last exactly 1 cycle, drive no outputs, and increment instr_cnt by 1 (wrapping 0xFFFF->0x0000); next state by opcode:
- NOP -> FETCH
- ALU, LDI, BZ, BN, JMP -> EXEC
- LD, ST -> MEM
- HALT -> HALT
- 0xE -> ERROR
REQ-021 EXEC SHALL last 1 cycle and then go to FETCH, driving:
- ALU: rf_we=1, wb_sel=0, alu_op valid.
- LDI: rf_we=1, wb_sel=1.
- BZ: pc_load=z_in.
- BN: pc_load=n_in.
- JMP: pc_load=1.
REQ-022 MEM SHALL drive addr_sel=1 and mem_rd=1 (LD) or mem_we=1 (ST), held until mem_rdy=1; then LD -> WB and ST -> FETCH.
REQ-023 WB SHALL last 1 cycle with rf_we=1, wb_sel=2, then go to FETCH.
REQ-024 A wait counter SHALL clear on entry to FETCH/MEM and count each cycle with mem_rdy=0; if it reaches FETCH_TIMEOUT with mem_rdy still 0, the next state is ERROR.
REQ-025 mem_rdy=1 in the same cycle the counter reaches FETCH_TIMEOUT SHALL count as success, not timeout.
REQ-026 HALT and ERROR SHALL be terminal until reset.
REQ-027 halted_out=1 SHALL hold in HALT and err_out=1 SHALL hold in ERROR; all strobes SHALL be 0 in both states.
REQ-028 mem_rd, mem_we and il_out SHALL never be asserted together, and il_out SHALL only assert in FETCH.
REQ-029 mem_rdy outside FETCH/MEM SHALL be ignored.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately, at any time including mid-transfer, force state=FETCH, wait counter=0 and instr_cnt=0.
REQ-031 While rst_n=0, every output SHALL be 0, combinationally gated.
REQ-032 FETCH behaviour (mem_rd=1) SHALL start in the first cycle after rst_n rises.

Verification
REQ-033 Reset release, mem_rdy=1 every cycle, ins_in=0x1000 (ALU) -> states 0,1,2,0; il_out/pc_inc pulse in cycle 0; rf_we=1, alu_op=1 in EXEC; instr_cnt=1.
REQ-034 ins_in=0x9000 (LD), mem_rdy low 3 cycles in MEM -> mem_rd held 4 MEM cycles with addr_sel=1, then WB with rf_we=1, wb_sel=2.
REQ-035 BZ with z_in=0, then BZ with z_in=1 -> pc_load 0 then 1; JMP -> pc_load=1.
REQ-036 FETCH with mem_rdy held 0, FETCH_TIMEOUT=15 -> ERROR entered after 15 wait cycles, err_out=1; mem_rdy on the 15th cycle instead -> DECODE.
REQ-037 Opcode 0xF -> halted_out=1 with all strobes 0 for 100 cycles; opcode 0xE -> err_out=1.
REQ-038 rst_n pulsed low mid-MEM -> outputs 0 immediately, instr_cnt=0, FETCH resumes after release.

Source files
------------

// File: rtl/cpu_ctrl_if.sv
// Memory-side bus of the cpu_ctrl sequencer: the read/write strobes, the address source
// select, and the completion flag that memory returns.
interface cpu_ctrl_if;
  // Handshake: the controller holds mem_rd or mem_we (with addr_sel) steady until memory
  // raises mem_rdy. A transfer completes on the rising edge where a strobe and mem_rdy
  // are both high. mem_rdy is ignored when no strobe is asserted.
  logic mem_rd;
  logic mem_we;
  logic addr_sel;
  logic mem_rdy;

  modport master (output mem_rd, output mem_we, output addr_sel, input mem_rdy);
  modport slave  (input mem_rd, input mem_we, input addr_sel, output mem_rdy);
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute/memory/writeback with a bounded
// memory wait and terminal HALT/ERROR states.
module cpu_ctrl #(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ins_in,
    input  logic        z_in,
    input  logic        n_in,
    cpu_ctrl_if.master  mem,
    output logic        il_out,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  alu_op,
    output logic [2:0]  state_out,
    output logic        halted_out,
    output logic        err_out,
    output logic [15:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // The last tolerated wait cycle is the one where the counter already holds TIMEOUT-1.
    localparam logic [7:0] WAIT_LIMIT = 8'(FETCH_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] cnt_q;
    logic [3:0]  opcode;

    logic il_c, pc_inc_c, pc_load_c, mem_rd_c, mem_we_c, addr_sel_c, rf_we_c;
    logic halted_c, err_c;
    logic [1:0] wb_sel_c;
    logic [2:0] alu_op_c;

    assign opcode = ins_in[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = 8'd0;
        il_c       = 1'b0;
        pc_inc_c   = 1'b0;
        pc_load_c  = 1'b0;
        mem_rd_c   = 1'b0;
        mem_we_c   = 1'b0;
        addr_sel_c = 1'b0;
        rf_we_c    = 1'b0;
        wb_sel_c   = 2'd0;
        alu_op_c   = 3'd0;
        halted_c   = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd_c = 1'b1;
                if (mem.mem_rdy) begin
                    il_c     = 1'b1;
                    pc_inc_c = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'h0:    state_d = S_FETCH;
                    4'h9,
                    4'hA:    state_d = S_MEM;
                    4'hE:    state_d = S_ERROR;
                    4'hF:    state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        rf_we_c  = 1'b1;
                        alu_op_c = opcode[2:0];
                    end
                    4'h8: begin
                        rf_we_c  = 1'b1;
                        wb_sel_c = 2'd1;
                    end
                    4'hB:    pc_load_c = z_in;
                    4'hC:    pc_load_c = n_in;
                    4'hD:    pc_load_c = 1'b1;
                    default: pc_load_c = 1'b0;
                endcase
            end
            S_MEM: begin
                addr_sel_c = 1'b1;
                mem_rd_c   = (opcode == 4'h9);
                mem_we_c   = (opcode != 4'h9);
                if (mem.mem_rdy) begin
                    state_d = (opcode == 4'h9) ? S_WB : S_FETCH;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                wb_sel_c = 2'd2;
                state_d  = S_FETCH;
            end
            S_HALT:  halted_c = 1'b1;
            S_ERROR: err_c = 1'b1;
            default: state_d = S_ERROR;
        endcase
    end

    // Every output is forced low while reset is held, independent of the clock.
    assign il_out       = rst_n & il_c;
    assign pc_inc       = rst_n & pc_inc_c;
    assign pc_load      = rst_n & pc_load_c;
    assign mem.mem_rd   = rst_n & mem_rd_c;
    assign mem.mem_we   = rst_n & mem_we_c;
    assign mem.addr_sel = rst_n & addr_sel_c;
    assign rf_we        = rst_n & rf_we_c;
    assign wb_sel       = rst_n ? wb_sel_c : 2'd0;
    assign alu_op       = rst_n ? alu_op_c : 3'd0;
    assign state_out    = rst_n ? state_q : 3'd0;
    assign halted_out   = rst_n & halted_c;
    assign err_out      = rst_n & err_c;
    assign instr_cnt    = rst_n ? cnt_q : 16'd0;

endmodule
